// File: rtl/grid_overlay_pkg.sv
// Shared types and constants for the grid/cursor video overlay.
//   rgb_t        : 24-bit packed RGB888 pixel (r = [23:16], g = [15:8], b = [7:0])
//   COLOR_*      : fixed overlay colours
//   COORD_W      : pixel coordinate width
package grid_overlay_pkg;

    localparam int unsigned COORD_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COLOR_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COLOR_GRID   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t COLOR_CURSOR = '{r: 8'hFF, g: 8'h00, b: 8'h00};

endpackage : grid_overlay_pkg

// File: rtl/grid_cell_locator.sv
// Combinational pixel classifier for the grid overlay.
// Ports:
//   i_x, i_y              : current pixel coordinate
//   i_cur_row, i_cur_col  : cell holding the cursor
//   o_in_image_c          : pixel inside the inclusive image rectangle
//   o_on_line_c           : pixel on an interior grid line
//   o_row_c, o_col_c      : cell index containing the pixel (clamped to GRID_N-1)
//   o_in_cursor_box_c     : pixel inside the inset cursor box of the cursor cell
module grid_cell_locator
    import grid_overlay_pkg::*;
#(
    parameter int unsigned GRID_N     = 4,
    parameter int unsigned CELL_W     = 100,
    parameter int unsigned ORIGIN_X   = 120,
    parameter int unsigned ORIGIN_Y   = 40,
    parameter int unsigned CUR_MARGIN = 25,
    localparam int unsigned IDX_W     = (GRID_N > 1) ? $clog2(GRID_N) : 1
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [IDX_W-1:0]   i_cur_row,
    input  logic [IDX_W-1:0]   i_cur_col,
    output logic               o_in_image_c,
    output logic               o_on_line_c,
    output logic [IDX_W-1:0]   o_row_c,
    output logic [IDX_W-1:0]   o_col_c,
    output logic               o_in_cursor_box_c
);

    localparam int unsigned SPAN = GRID_N * CELL_W;

    int unsigned w_xi;
    int unsigned w_yi;
    int unsigned w_xbase;
    int unsigned w_ybase;
    logic        w_line_hit;
    logic        w_box_x;
    logic        w_box_y;

    assign w_xi = 32'(i_x);
    assign w_yi = 32'(i_y);

    // Both edges of the image rectangle are inclusive.
    assign o_in_image_c = (w_xi >= ORIGIN_X) && (w_xi <= ORIGIN_X + SPAN) &&
                          (w_yi >= ORIGIN_Y) && (w_yi <= ORIGIN_Y + SPAN);

    // Cell index = number of interior line positions at or left of / above the pixel.
    always_comb begin
        o_row_c    = '0;
        o_col_c    = '0;
        w_line_hit = 1'b0;
        for (int unsigned k = 1; k < GRID_N; k++) begin
            if (w_xi >= ORIGIN_X + k * CELL_W) o_col_c = IDX_W'(k);
            if (w_yi >= ORIGIN_Y + k * CELL_W) o_row_c = IDX_W'(k);
            if ((w_xi == ORIGIN_X + k * CELL_W) || (w_yi == ORIGIN_Y + k * CELL_W)) begin
                w_line_hit = 1'b1;
            end
        end
    end

    assign o_on_line_c = o_in_image_c && w_line_hit;

    // Cursor box is an inclusive inset window measured from the cursor cell origin.
    assign w_xbase = ORIGIN_X + 32'(i_cur_col) * CELL_W;
    assign w_ybase = ORIGIN_Y + 32'(i_cur_row) * CELL_W;
    assign w_box_x = (w_xi >= w_xbase + CUR_MARGIN) && (w_xi <= w_xbase + CELL_W - CUR_MARGIN);
    assign w_box_y = (w_yi >= w_ybase + CUR_MARGIN) && (w_yi <= w_ybase + CELL_W - CUR_MARGIN);

    assign o_in_cursor_box_c = o_in_image_c && w_box_x && w_box_y;

endmodule : grid_cell_locator

// File: rtl/grid_cursor_overlay.sv
// Grid and cursor overlay on a streaming RGB888 image, with cursor movement
// and a selection handshake.
// Ports:
//   clk, reset            : pixel clock, synchronous active-high reset
//   x, y, pixel_in        : current pixel coordinate and image data
//   frame_start           : one-cycle pulse per frame; moves and raw_mode take effect here
//   raw_mode              : image-only display (latched on frame_start)
//   move_up/down/left/right, select, sel_ack : control pulses
//   cursor_pos            : row*GRID_N+col of the cursor
//   sel_valid, sel_pos    : pending selection and its captured position
//   red, green, blue      : registered output colour, 1 clk after x/y/pixel_in
// Build option: define GRID_CURSOR_BLINK_EN to blink the cursor every
// BLINK_FRAMES frames; otherwise the cursor is always visible.
module grid_cursor_overlay
    import grid_overlay_pkg::*;
#(
    parameter int unsigned GRID_N       = 4,
    parameter int unsigned CELL_W       = 100,
    parameter int unsigned ORIGIN_X     = 120,
    parameter int unsigned ORIGIN_Y     = 40,
    parameter int unsigned CUR_MARGIN   = 25,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned POS_W       = $clog2(GRID_N * GRID_N),
    localparam int unsigned IDX_W       = (GRID_N > 1) ? $clog2(GRID_N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_start,
    input  logic               raw_mode,
    input  logic [23:0]        pixel_in,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               select,
    input  logic               sel_ack,
    output logic [POS_W-1:0]   cursor_pos,
    output logic               sel_valid,
    output logic [POS_W-1:0]   sel_pos,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue
);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic             r_up;
    logic             r_down;
    logic             r_left;
    logic             r_right;
    logic             r_raw;
    logic             r_sel_valid;
    logic [POS_W-1:0] r_sel_pos;
    rgb_t             r_rgb;

    logic             w_up;
    logic             w_down;
    logic             w_left;
    logic             w_right;
    logic [IDX_W-1:0] w_row_next;
    logic [IDX_W-1:0] w_col_next;
    logic             w_move_apply;
    logic             w_visible;
    logic             w_in_image;
    logic             w_on_line;
    logic [IDX_W-1:0] w_pix_row;
    logic [IDX_W-1:0] w_pix_col;
    logic             w_in_box;
    logic             w_cursor_hit;
    logic [POS_W-1:0] w_cursor_pos;
    rgb_t             w_rgb;

    grid_cell_locator #(
        .GRID_N     (GRID_N),
        .CELL_W     (CELL_W),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .CUR_MARGIN (CUR_MARGIN)
    ) u_locator (
        .i_x               (x),
        .i_y               (y),
        .i_cur_row         (r_row),
        .i_cur_col         (r_col),
        .o_in_image_c      (w_in_image),
        .o_on_line_c       (w_on_line),
        .o_row_c           (w_pix_row),
        .o_col_c           (w_pix_col),
        .o_in_cursor_box_c (w_in_box)
    );

    // A pulse arriving with frame_start joins the pending set for that frame.
    assign w_up    = r_up    | move_up;
    assign w_down  = r_down  | move_down;
    assign w_left  = r_left  | move_left;
    assign w_right = r_right | move_right;

    // Next cursor cell: opposing requests cancel per axis, each axis wraps.
    always_comb begin
        w_row_next = r_row;
        w_col_next = r_col;
        if (w_up && !w_down) begin
            w_row_next = (r_row == '0) ? IDX_W'(GRID_N - 1) : r_row - IDX_W'(1);
        end else if (w_down && !w_up) begin
            w_row_next = (r_row == IDX_W'(GRID_N - 1)) ? '0 : r_row + IDX_W'(1);
        end
        if (w_left && !w_right) begin
            w_col_next = (r_col == '0) ? IDX_W'(GRID_N - 1) : r_col - IDX_W'(1);
        end else if (w_right && !w_left) begin
            w_col_next = (r_col == IDX_W'(GRID_N - 1)) ? '0 : r_col + IDX_W'(1);
        end
    end

    assign w_move_apply = frame_start && ((w_up ^ w_down) || (w_left ^ w_right));

    assign w_cursor_pos = POS_W'(32'(r_row) * GRID_N + 32'(r_col));

`ifdef GRID_CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_visible;

    // Frame counter toggles visibility on wrap; any applied move restarts the blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (w_move_apply) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (frame_start) begin
            if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_visible   <= ~r_visible;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign w_visible = r_visible;
`else
    assign w_visible = 1'b1;
`endif

    // Cell indices from the locator are re-checked against the registered cursor.
    assign w_cursor_hit = w_in_box && w_visible &&
                          (w_pix_row == r_row) && (w_pix_col == r_col);

    // Colour priority: outside -> black, raw -> image, cursor, grid line, image.
    always_comb begin
        w_rgb = rgb_t'(pixel_in);
        if (!w_in_image) begin
            w_rgb = COLOR_BLACK;
        end else if (!r_raw) begin
            if (w_cursor_hit) begin
                w_rgb = COLOR_CURSOR;
            end else if (w_on_line) begin
                w_rgb = COLOR_GRID;
            end
        end
    end

    // Cursor, pending moves, raw latch, selection handshake and output colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_left      <= 1'b0;
            r_right     <= 1'b0;
            r_raw       <= 1'b0;
            r_sel_valid <= 1'b0;
            r_sel_pos   <= '0;
            r_rgb       <= COLOR_BLACK;
        end else begin
            if (frame_start) begin
                r_row   <= w_row_next;
                r_col   <= w_col_next;
                r_up    <= 1'b0;
                r_down  <= 1'b0;
                r_left  <= 1'b0;
                r_right <= 1'b0;
                r_raw   <= raw_mode;
            end else begin
                r_up    <= w_up;
                r_down  <= w_down;
                r_left  <= w_left;
                r_right <= w_right;
            end

            // A new select is accepted when idle, or when the pending one is acked the same cycle.
            if (select && (!r_sel_valid || sel_ack)) begin
                r_sel_valid <= 1'b1;
                r_sel_pos   <= w_cursor_pos;
            end else if (sel_ack) begin
                r_sel_valid <= 1'b0;
            end

            r_rgb <= w_rgb;
        end
    end

    assign cursor_pos = w_cursor_pos;
    assign sel_valid  = r_sel_valid;
    assign sel_pos    = r_sel_pos;
    assign red        = r_rgb.r;
    assign green      = r_rgb.g;
    assign blue       = r_rgb.b;

endmodule : grid_cursor_overlay
